// File: rtl/fto_truth_scanner.sv
// fto_truth_scanner: steps a 4-input cell through all 16 vectors and captures its truth table.
// Each vector is held SETTLE cycles before sampling; X/Z samples are flagged (simulation only).
module fto_truth_scanner #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        xz_flag
);
    typedef enum logic {IDLE, SCAN} state_t;
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);
    state_t      state, state_n;
    logic [3:0]  vec, vec_n, cnt, cnt_n;
    logic [15:0] acc, acc_n, table_n;
    logic        sticky, sticky_n, xz_n, done_n;
    logic        f_bit, f_xz;
    // Case-equality keeps X/Z out of the table; synthesis sees f_xz as constant 0.
    assign f_bit = (f_in === 1'b1);
    assign f_xz  = (f_in !== 1'b0) && (f_in !== 1'b1);
    assign {a, b, c, d} = vec;
    assign busy = (state == SCAN);
    always_comb begin
        state_n  = state;
        vec_n    = vec;
        cnt_n    = cnt;
        acc_n    = acc;
        sticky_n = sticky;
        table_n  = table_out;
        xz_n     = xz_flag;
        done_n   = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_n  = SCAN;
                vec_n    = 4'd0;
                cnt_n    = RELOAD;
                acc_n    = 16'h0000;
                sticky_n = 1'b0;
            end
        end else if (cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
        end else begin
            acc_n[vec] = f_bit;
            sticky_n   = sticky | f_xz;
            if (vec != 4'd15) begin
                vec_n = vec + 4'd1;
                cnt_n = RELOAD;
            end else begin
                state_n = IDLE;
                vec_n   = 4'd0;
                table_n = acc_n;
                xz_n    = sticky_n;
                done_n  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= 4'd0;
            cnt       <= 4'd0;
            acc       <= 16'h0000;
            sticky    <= 1'b0;
            table_out <= 16'h0000;
            xz_flag   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            vec       <= vec_n;
            cnt       <= cnt_n;
            acc       <= acc_n;
            sticky    <= sticky_n;
            table_out <= table_n;
            xz_flag   <= xz_n;
            done      <= done_n;
        end
    end
endmodule

// File: tb/tb_fto_truth_scanner.sv
// tb_fto_truth_scanner: directed checks of the scanner with the real cell (SETTLE=2)
// and a parity function (SETTLE=1).
module tb_fto_truth_scanner;
    logic        clk = 1'b0, rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0, f_in0, f_in1, zv = 1'b0;
    logic        a0, b0, c0, d0, busy0, done0, xz0;
    logic        a1, b1, c1, d1, busy1, done1, xz1;
    logic [15:0] tab0, tab1;
    logic        probe;
    logic        four;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    fto_truth_scanner #(.SETTLE(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .f_in(f_in0),
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
        .table_out(tab0), .xz_flag(xz0)
    );
    fto_truth_scanner #(.SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .f_in(f_in1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .table_out(tab1), .xz_flag(xz1)
    );

    function automatic logic cellf(input logic [3:0] v);
        logic fa, fb, fc, fd;
        {fa, fb, fc, fd} = v;
        return (fa & fd) | (fa & ~fb & fc) | (fb & ~fd) | (~fa & ~fc & ~fd);
    endfunction

    always_comb f_in0 = (zv && {a0, b0, c0, d0} == 4'd5) ? 1'bz : cellf({a0, b0, c0, d0});
    always_comb f_in1 = a1 ^ b1 ^ c1 ^ d1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_scan(input bit sel, output int n);
        int s;
        s = sel ? 1 : 2;
        n = 0;
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        while (!(sel ? done1 : done0) && n < 200) begin
            chk("vec", sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0}, 32'(n / s));
            chk("busy", sel ? busy1 : busy0, 1);
            if (sel) start1 = (n == 5);
            @(negedge clk);
            n++;
        end
        chk("latency", n, 16 * s);
        chk("done_busy", sel ? busy1 : busy0, 0);
        chk("done_vec", sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0}, 0);
        @(negedge clk);
        chk("done_pulse", sel ? done1 : done0, 0);
    endtask

    initial begin
        int n, bad;
        probe = 1'bz;
        four  = (probe !== 1'b0) && (probe !== 1'b1);
        #12 chk("rst_async_tab", tab0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_out", {tab0, xz0, busy0, done0, a0, b0, c0, d0}, 0);
        end
        run_scan(0, n);
        chk("cell_table", tab0, 16'hFE51);
        chk("cell_xz", xz0, 0);
        run_scan(1, n);
        chk("parity_table", tab1, 16'h6996);
        chk("parity_xz", xz1, 0);
        zv = 1'b1;
        run_scan(0, n);
        zv = 1'b0;
        chk("z_table", tab0, 16'hFE51);
        chk("z_flag", xz0, 32'(four));
        run_scan(0, n);
        chk("clean_xz", xz0, 0);
        chk("clean_table", tab0, 16'hFE51);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while ({a0, b0, c0, d0} != 4'd9 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach9", {a0, b0, c0, d0}, 9);
        chk("mid_hold_tab", tab0, 16'hFE51);
        #2 rst = 1'b1;
        #1 chk("mid_rst_out", {tab0, xz0, busy0, done0, a0, b0, c0, d0}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {tab0, busy0, a0, b0, c0, d0}, 0);
        run_scan(0, n);
        chk("post_rst_table", tab0, 16'hFE51);
        @(negedge clk);
        start0 = 1'b1;
        n = 0;
        while (!done0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first", n, 33);
        bad = 0;
        repeat (2) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (busy0 == done0 || tab0 != 16'hFE51) bad++;
            end while (!done0 && n < 100);
            chk("b2b_period", n, 33);
        end
        start0 = 1'b0;
        chk("b2b_busy_tab", bad, 0);
        @(negedge clk);
        chk("b2b_stop", busy0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
